// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: converts a valid/ready command stream into single
// bus cycles with bounded retry and an ack timeout, returning one response each.
module wb_cmd_master #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRY      = 0
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  input  logic        cmd_we,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic [1:0]  rsp_status,
  output logic [31:0] wb_m2s_adr,
  output logic [31:0] wb_m2s_dat,
  output logic [3:0]  wb_m2s_sel,
  output logic        wb_m2s_we,
  output logic        wb_m2s_cyc,
  output logic        wb_m2s_stb,
  input  logic [31:0] wb_s2m_dat,
  input  logic        wb_s2m_ack,
  input  logic        wb_s2m_err,
  input  logic        wb_s2m_rty
);

  localparam int TW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT_CYCLES);
  localparam logic [RW-1:0] RTY_LIMIT = RW'(MAX_RETRY);

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ERR = 2'b01;
  localparam logic [1:0] ST_RTY = 2'b10;
  localparam logic [1:0] ST_TO  = 2'b11;

  typedef enum logic [1:0] {IDLE, BUS, GAP, RESP} state_t;

  state_t        state_reg, state_next;
  logic [31:0]   adr_reg, adr_next;
  logic [31:0]   dat_reg, dat_next;
  logic [3:0]    sel_reg, sel_next;
  logic          we_reg, we_next;
  logic          cyc_reg, cyc_next;
  logic          rsp_valid_reg, rsp_valid_next;
  logic [31:0]   rsp_dat_reg, rsp_dat_next;
  logic [1:0]    rsp_status_reg, rsp_status_next;
  logic [TW-1:0] to_reg, to_next;
  logic [RW-1:0] rty_reg, rty_next;
  logic [TW-1:0] to_inc;

  assign to_inc = to_reg + TW'(1);

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_reg      <= IDLE;
      adr_reg        <= '0;
      dat_reg        <= '0;
      sel_reg        <= '0;
      we_reg         <= 1'b0;
      cyc_reg        <= 1'b0;
      rsp_valid_reg  <= 1'b0;
      rsp_dat_reg    <= '0;
      rsp_status_reg <= ST_OK;
      to_reg         <= '0;
      rty_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      adr_reg        <= adr_next;
      dat_reg        <= dat_next;
      sel_reg        <= sel_next;
      we_reg         <= we_next;
      cyc_reg        <= cyc_next;
      rsp_valid_reg  <= rsp_valid_next;
      rsp_dat_reg    <= rsp_dat_next;
      rsp_status_reg <= rsp_status_next;
      to_reg         <= to_next;
      rty_reg        <= rty_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    adr_next        = adr_reg;
    dat_next        = dat_reg;
    sel_next        = sel_reg;
    we_next         = we_reg;
    cyc_next        = cyc_reg;
    rsp_valid_next  = rsp_valid_reg;
    rsp_dat_next    = rsp_dat_reg;
    rsp_status_next = rsp_status_reg;
    to_next         = to_reg;
    rty_next        = rty_reg;

    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          adr_next   = cmd_adr;
          dat_next   = cmd_dat;
          sel_next   = cmd_sel;
          we_next    = cmd_we;
          cyc_next   = 1'b1;
          to_next    = '0;
          rty_next   = '0;
          state_next = BUS;
        end
      end
      BUS: begin
        // err outranks rty, which outranks ack
        if (wb_s2m_err) begin
          cyc_next        = 1'b0;
          rsp_dat_next    = '0;
          rsp_status_next = ST_ERR;
          rsp_valid_next  = 1'b1;
          state_next      = RESP;
        end else if (wb_s2m_rty) begin
          cyc_next = 1'b0;
          if (MAX_RETRY != 0 && rty_reg < RTY_LIMIT) begin
            rty_next   = rty_reg + RW'(1);
            state_next = GAP;
          end else begin
            rsp_dat_next    = '0;
            rsp_status_next = ST_RTY;
            rsp_valid_next  = 1'b1;
            state_next      = RESP;
          end
        end else if (wb_s2m_ack) begin
          cyc_next        = 1'b0;
          rsp_dat_next    = we_reg ? 32'h0 : wb_s2m_dat;
          rsp_status_next = ST_OK;
          rsp_valid_next  = 1'b1;
          state_next      = RESP;
        end else begin
          to_next = to_inc;
          if (TIMEOUT_CYCLES != 0 && to_inc == TO_LIMIT) begin
            cyc_next        = 1'b0;
            rsp_dat_next    = '0;
            rsp_status_next = ST_TO;
            rsp_valid_next  = 1'b1;
            state_next      = RESP;
          end
        end
      end
      GAP: begin
        cyc_next   = 1'b1;
        to_next    = '0;
        state_next = BUS;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign cmd_ready  = (state_reg == IDLE);
  assign rsp_valid  = rsp_valid_reg;
  assign rsp_dat    = rsp_dat_reg;
  assign rsp_status = rsp_status_reg;
  assign wb_m2s_adr = adr_reg;
  assign wb_m2s_dat = dat_reg;
  assign wb_m2s_sel = sel_reg;
  assign wb_m2s_we  = we_reg;
  assign wb_m2s_cyc = cyc_reg;
  assign wb_m2s_stb = cyc_reg;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: a scripted slave answers each bus attempt,
// and responses, pulse counts and cycle lengths are compared to hand values.
module tb_wb_cmd_master;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        cmd_we;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;
  logic [31:0] wb_m2s_adr, wb_m2s_dat;
  logic [3:0]  wb_m2s_sel;
  logic        wb_m2s_we, wb_m2s_cyc, wb_m2s_stb;
  logic [31:0] wb_s2m_dat;
  logic        wb_s2m_ack, wb_s2m_err, wb_s2m_rty;

  wb_cmd_master #(.TIMEOUT_CYCLES(16), .MAX_RETRY(2)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel), .cmd_we(cmd_we),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_dat(rsp_dat), .rsp_status(rsp_status),
    .wb_m2s_adr(wb_m2s_adr), .wb_m2s_dat(wb_m2s_dat), .wb_m2s_sel(wb_m2s_sel),
    .wb_m2s_we(wb_m2s_we), .wb_m2s_cyc(wb_m2s_cyc), .wb_m2s_stb(wb_m2s_stb),
    .wb_s2m_dat(wb_s2m_dat), .wb_s2m_ack(wb_s2m_ack),
    .wb_s2m_err(wb_s2m_err), .wb_s2m_rty(wb_s2m_rty)
  );

  always #5 wb_clk = ~wb_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // slave script per attempt: kind 0 silent, 1 ack, 2 err, 3 rty, 4 err+ack
  int          plan_kind [4];
  int          plan_dly  [4];
  logic [31:0] plan_dat;

  int          pulses, hi_cnt;
  logic        gap_bad, stable_bad;
  logic [31:0] seen_adr, seen_dat;
  logic [3:0]  seen_sel;
  logic        seen_we;
  logic [31:0] got_dat;
  logic [1:0]  got_status;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_plan(input int k0, d0, k1, d1, k2, d2, k3, d3, input logic [31:0] d);
    plan_kind[0] = k0; plan_dly[0] = d0;
    plan_kind[1] = k1; plan_dly[1] = d1;
    plan_kind[2] = k2; plan_dly[2] = d2;
    plan_kind[3] = k3; plan_dly[3] = d3;
    plan_dat = d;
  endtask

  task automatic do_cmd(input string name, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic we, input int hold);
    int   cyc_cnt = 0;
    int   att = 0;
    int   gap_len = 0;
    logic prev = 1'b0;
    pulses = 0; hi_cnt = 0; gap_bad = 1'b0; stable_bad = 1'b0;
    @(negedge wb_clk);
    check({name, "_cmd_ready"}, {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_we = we;
    @(posedge wb_clk);
    for (int i = 0; i < 200; i++) begin
      @(negedge wb_clk);
      cmd_valid  = 1'b0;
      wb_s2m_ack = 1'b0; wb_s2m_err = 1'b0; wb_s2m_rty = 1'b0;
      wb_s2m_dat = 32'h0;
      if (wb_m2s_stb !== wb_m2s_cyc) stable_bad = 1'b1;
      if (wb_m2s_cyc) begin
        if (!prev) begin
          if (pulses > 0 && gap_len != 1) gap_bad = 1'b1;
          pulses++;
          cyc_cnt = 0;
        end
        cyc_cnt++;
        hi_cnt++;
        if (hi_cnt == 1) begin
          seen_adr = wb_m2s_adr; seen_dat = wb_m2s_dat;
          seen_sel = wb_m2s_sel; seen_we  = wb_m2s_we;
        end else if (wb_m2s_adr !== seen_adr || wb_m2s_dat !== seen_dat ||
                     wb_m2s_sel !== seen_sel || wb_m2s_we !== seen_we) begin
          stable_bad = 1'b1;
        end
        wb_s2m_dat = plan_dat;
        if (att < 4 && cyc_cnt == plan_dly[att]) begin
          case (plan_kind[att])
            1: wb_s2m_ack = 1'b1;
            2: wb_s2m_err = 1'b1;
            3: wb_s2m_rty = 1'b1;
            4: begin wb_s2m_err = 1'b1; wb_s2m_ack = 1'b1; end
            default: ;
          endcase
        end
      end else begin
        if (prev) begin
          att++;
          gap_len = 0;
        end
        gap_len++;
        if (rsp_valid) break;
      end
      prev = wb_m2s_cyc;
    end
    check({name, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
    check({name, "_bus_stable"}, {31'b0, stable_bad}, 32'd0);
    check({name, "_gap_1cyc"}, {31'b0, gap_bad}, 32'd0);
    check({name, "_adr"}, seen_adr, adr);
    check({name, "_we"}, {31'b0, seen_we}, {31'b0, we});
    got_dat    = rsp_dat;
    got_status = rsp_status;
    for (int h = 0; h < hold; h++) begin
      @(negedge wb_clk);
      check({name, "_hold_valid"}, {31'b0, rsp_valid}, 32'd1);
      check({name, "_hold_dat"}, rsp_dat, got_dat);
      check({name, "_hold_status"}, {30'b0, rsp_status}, {30'b0, got_status});
      check({name, "_hold_cmd_ready"}, {31'b0, cmd_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge wb_clk);
    @(negedge wb_clk);
    rsp_ready = 1'b0;
    check({name, "_rsp_drop"}, {31'b0, rsp_valid}, 32'd0);
    check({name, "_ready_after"}, {31'b0, cmd_ready}, 32'd1);
    $display("[TB] txn %s adr=0x%08h we=%0d status=%0d dat=0x%08h pulses=%0d cyc_hi=%0d",
             name, adr, we, got_status, got_dat, pulses, hi_cnt);
  endtask

  initial begin
    wb_rst = 1'b1;
    cmd_valid = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0; cmd_we = 1'b0;
    rsp_ready = 1'b0;
    wb_s2m_dat = '0; wb_s2m_ack = 1'b0; wb_s2m_err = 1'b0; wb_s2m_rty = 1'b0;
    set_plan(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    repeat (2) @(negedge wb_clk);
    check("rst_cyc", {31'b0, wb_m2s_cyc}, 32'd0);
    check("rst_stb", {31'b0, wb_m2s_stb}, 32'd0);
    check("rst_adr", wb_m2s_adr, 32'h0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_dat", rsp_dat, 32'h0);
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    wb_rst = 1'b0;

    set_plan(1, 3, 0, 0, 0, 0, 0, 0, 32'hCAFE0000);
    do_cmd("wr_ack3", 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 0);
    check("wr_ack3_status", {30'b0, got_status}, 32'd0);
    check("wr_ack3_dat", got_dat, 32'h0);
    check("wr_ack3_hi", hi_cnt, 3);
    check("wr_ack3_wdat", seen_dat, 32'hDEADBEEF);
    check("wr_ack3_sel", {28'b0, seen_sel}, 32'hF);

    set_plan(1, 1, 0, 0, 0, 0, 0, 0, 32'h000000A5);
    do_cmd("rd_ack1", 32'h04, 32'h0, 4'hF, 1'b0, 0);
    check("rd_ack1_status", {30'b0, got_status}, 32'd0);
    check("rd_ack1_dat", got_dat, 32'h000000A5);
    check("rd_ack1_hi", hi_cnt, 1);

    set_plan(0, 0, 0, 0, 0, 0, 0, 0, 32'h11111111);
    do_cmd("timeout", 32'h20, 32'h0, 4'h1, 1'b0, 0);
    check("timeout_status", {30'b0, got_status}, 32'd3);
    check("timeout_dat", got_dat, 32'h0);
    check("timeout_hi", hi_cnt, 16);

    set_plan(3, 1, 3, 1, 1, 1, 0, 0, 32'h12345678);
    do_cmd("rty2_ack", 32'h30, 32'h0, 4'hF, 1'b0, 0);
    check("rty2_ack_status", {30'b0, got_status}, 32'd0);
    check("rty2_ack_dat", got_dat, 32'h12345678);
    check("rty2_ack_pulses", pulses, 3);

    set_plan(3, 1, 3, 2, 3, 1, 3, 1, 32'h0);
    do_cmd("rty4", 32'h34, 32'hA5A5A5A5, 4'h3, 1'b1, 0);
    check("rty4_status", {30'b0, got_status}, 32'd2);
    check("rty4_dat", got_dat, 32'h0);
    check("rty4_pulses", pulses, 3);
    check("rty4_hi", hi_cnt, 4);

    set_plan(4, 2, 0, 0, 0, 0, 0, 0, 32'h55AA55AA);
    do_cmd("err_ack", 32'h40, 32'h0, 4'hF, 1'b0, 5);
    check("err_ack_status", {30'b0, got_status}, 32'd1);
    check("err_ack_dat", got_dat, 32'h0);
    check("err_ack_hi", hi_cnt, 2);

    // terminations while idle must not start or end anything
    @(negedge wb_clk);
    wb_s2m_ack = 1'b1; wb_s2m_rty = 1'b1;
    repeat (3) begin
      @(negedge wb_clk);
      check("stray_cyc", {31'b0, wb_m2s_cyc}, 32'd0);
      check("stray_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    end
    wb_s2m_ack = 1'b0; wb_s2m_rty = 1'b0;

    // asynchronous reset in the middle of a bus cycle
    @(negedge wb_clk);
    cmd_valid = 1'b1; cmd_adr = 32'h50; cmd_we = 1'b1;
    @(negedge wb_clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge wb_clk);
    check("midrst_cyc_before", {31'b0, wb_m2s_cyc}, 32'd1);
    #2 wb_rst = 1'b1;
    #1;
    check("midrst_cyc", {31'b0, wb_m2s_cyc}, 32'd0);
    check("midrst_stb", {31'b0, wb_m2s_stb}, 32'd0);
    check("midrst_we", {31'b0, wb_m2s_we}, 32'd0);
    @(negedge wb_clk);
    wb_rst = 1'b0;
    @(negedge wb_clk);
    check("postrst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("postrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("postrst_cyc", {31'b0, wb_m2s_cyc}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
